// File: rtl/muldiv_unit.sv
// Iterative MIPS multiply/divide unit: 33-cycle MULT/MULTU/DIV/DIVU into HI/LO,
// plus single-cycle MTHI/MTLO.
module muldiv_unit #(
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [2:0]    op,
  input  logic [DW-1:0] in1,
  input  logic [DW-1:0] in2,
  input  logic          flush,
  output logic          busy,
  output logic          done,
  output logic [DW-1:0] hi,
  output logic [DW-1:0] lo
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIX  = 2'd2
  } state_t;

  localparam logic [2:0] OP_MTHI = 3'b100;
  localparam logic [2:0] OP_MTLO = 3'b101;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [5:0]    r_cnt;

  // Operand/iteration registers, shared by multiply and divide.
  logic          r_is_div;
  logic          r_sign1;
  logic          r_sign2;
  logic          r_div0;
  logic [DW-1:0] r_opa;
  logic [DW-1:0] r_opb;
  logic [DW-1:0] r_acc_hi;
  logic [DW-1:0] r_acc_lo;

  logic [DW-1:0] r_hi;
  logic [DW-1:0] r_lo;
  logic          r_done;

  logic          w_busy;
  logic          w_load;
  logic          w_step;
  logic          w_fix;
  logic          w_mthi;
  logic          w_mtlo;

  logic          w_is_muldiv;
  logic          w_is_signed;
  logic          w_sign1;
  logic          w_sign2;
  logic [DW-1:0] w_abs1;
  logic [DW-1:0] w_abs2;

  logic [DW:0]   w_mul_sum;
  logic [DW:0]   w_rem_shift;
  logic [DW-1:0] w_div_diff;
  logic          w_div_ge;

  logic [2*DW-1:0] w_prod;
  logic [2*DW-1:0] w_prod_fix;
  logic [DW-1:0]   w_quo_fix;
  logic [DW-1:0]   w_rem_fix;
  logic [DW-1:0]   w_in1_orig;
  logic [DW-1:0]   w_res_hi;
  logic [DW-1:0]   w_res_lo;

  // Operand decode: MULT=000 and DIV=010 are the signed ops.
  assign w_is_muldiv = (op[2] == 1'b0);
  assign w_is_signed = (op[2] == 1'b0) && (op[0] == 1'b0);
  assign w_sign1     = w_is_signed && in1[DW-1];
  assign w_sign2     = w_is_signed && in2[DW-1];
  assign w_abs1      = w_sign1 ? -in1 : in1;
  assign w_abs2      = w_sign2 ? -in2 : in2;

  // Shift-add multiply step: accumulator in r_acc_hi, multiplier shifting out of r_acc_lo.
  assign w_mul_sum   = {1'b0, r_acc_hi} + ({1'b0, r_opa} & {(DW+1){r_acc_lo[0]}});

  // Restoring divide step: remainder in r_acc_hi, dividend shifting out of r_acc_lo.
  assign w_rem_shift = {r_acc_hi, r_acc_lo[DW-1]};
  assign w_div_ge    = (w_rem_shift >= {1'b0, r_opb});
  assign w_div_diff  = w_rem_shift[DW-1:0] - r_opb;

  // Sign correction applied in FIX.
  assign w_prod      = {r_acc_hi, r_acc_lo};
  assign w_prod_fix  = (r_sign1 ^ r_sign2) ? -w_prod : w_prod;
  assign w_quo_fix   = (r_sign1 ^ r_sign2) ? -r_acc_lo : r_acc_lo;
  assign w_rem_fix   = r_sign1 ? -r_acc_hi : r_acc_hi;
  assign w_in1_orig  = r_sign1 ? -r_opa : r_opa;

  always_comb begin
    w_res_hi = w_prod_fix[2*DW-1:DW];
    w_res_lo = w_prod_fix[DW-1:0];
    if (r_is_div) begin
      if (r_div0) begin
        w_res_hi = w_in1_orig;
        w_res_lo = '1;
      end else begin
        w_res_hi = w_rem_fix;
        w_res_lo = w_quo_fix;
      end
    end
  end

  // FSM: state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      r_state <= w_state_nxt;
      if (flush || w_load) begin
        r_cnt <= '0;
      end else if (w_step) begin
        r_cnt <= r_cnt + 6'd1;
      end
    end
  end

  // FSM: next-state logic; flush overrides everything.
  always_comb begin
    // NOTE: default first so no path through this block leaves w_state_nxt unassigned (no latch).
    w_state_nxt = r_state;
    if (flush) begin
      w_state_nxt = S_IDLE;
    end else begin
      unique case (r_state)
        S_IDLE:  if (start && w_is_muldiv) w_state_nxt = S_RUN;
        S_RUN:   if (r_cnt == 6'(DW-1))    w_state_nxt = S_FIX;
        S_FIX:   w_state_nxt = S_IDLE;
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  // FSM: output decode, from registered state only (plus the start/flush qualifiers).
  always_comb begin
    w_busy = 1'b0;
    w_load = 1'b0;
    w_step = 1'b0;
    w_fix  = 1'b0;
    w_mthi = 1'b0;
    w_mtlo = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        w_load = start && !flush && w_is_muldiv;
        w_mthi = start && !flush && (op == OP_MTHI);
        w_mtlo = start && !flush && (op == OP_MTLO);
      end
      S_RUN: begin
        w_busy = 1'b1;
        w_step = !flush;
      end
      S_FIX: begin
        w_busy = 1'b1;
        w_fix  = !flush;
      end
      default: w_busy = 1'b0;
    endcase
  end

  // Operand capture and iteration datapath.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_is_div <= 1'b0;
      r_sign1  <= 1'b0;
      r_sign2  <= 1'b0;
      r_div0   <= 1'b0;
      r_opa    <= '0;
      r_opb    <= '0;
      r_acc_hi <= '0;
      r_acc_lo <= '0;
    end else if (w_load) begin
      r_is_div <= op[1];
      r_sign1  <= w_sign1;
      r_sign2  <= w_sign2;
      r_div0   <= (in2 == '0);
      r_opa    <= w_abs1;
      r_opb    <= w_abs2;
      r_acc_hi <= '0;
      r_acc_lo <= op[1] ? w_abs1 : w_abs2;
    end else if (w_step) begin
      if (r_is_div) begin
        r_acc_hi <= w_div_ge ? w_div_diff : w_rem_shift[DW-1:0];
        r_acc_lo <= {r_acc_lo[DW-2:0], w_div_ge};
      end else begin
        r_acc_hi <= w_mul_sum[DW:1];
        r_acc_lo <= {w_mul_sum[0], r_acc_lo[DW-1:1]};
      end
    end
  end

  // Architectural HI/LO: written only at FIX or by MTHI/MTLO.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_hi   <= '0;
      r_lo   <= '0;
      r_done <= 1'b0;
    end else begin
      r_done <= w_fix;
      if (w_fix) begin
        r_hi <= w_res_hi;
        r_lo <= w_res_lo;
      end else if (w_mthi) begin
        r_hi <= in1;
      end else if (w_mtlo) begin
        r_lo <= in1;
      end
    end
  end

  assign busy = w_busy;
  assign done = r_done;
  assign hi   = r_hi;
  assign lo   = r_lo;

  // The hazard unit must never issue a mul/div-class instruction while busy.
  a_no_start_while_busy: assert property (@(posedge clk) disable iff (reset)
    !(start && w_busy && !flush));

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed cases plus randomized ops
// compared against a plain-arithmetic HI/LO model.
module tb_muldiv_unit;

  localparam logic [2:0] MULT  = 3'b000;
  localparam logic [2:0] MULTU = 3'b001;
  localparam logic [2:0] DIV   = 3'b010;
  localparam logic [2:0] DIVU  = 3'b011;
  localparam logic [2:0] MTHI  = 3'b100;
  localparam logic [2:0] MTLO  = 3'b101;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [2:0]  op;
  logic [31:0] in1;
  logic [31:0] in2;
  logic        flush;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  int n_checks = 0;
  int n_pass   = 0;

  // Architectural HI/LO as the bench expects them.
  logic [31:0] m_hi;
  logic [31:0] m_lo;

  muldiv_unit #(.DW(32)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .op    (op),
    .in1   (in1),
    .in2   (in2),
    .flush (flush),
    .busy  (busy),
    .done  (done),
    .hi    (hi),
    .lo    (lo)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  // Reference result from the architectural definition of each op.
  task automatic model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] eh, output logic [31:0] el);
    longint      sa;
    longint      sb;
    longint      q;
    longint      r;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    eh = 32'h0;
    el = 32'h0;
    case (o)
      MULT: begin
        p  = 64'(sa * sb);
        eh = p[63:32];
        el = p[31:0];
      end
      MULTU: begin
        p  = {32'h0, a} * {32'h0, b};
        eh = p[63:32];
        el = p[31:0];
      end
      DIV, DIVU: begin
        if (b == 32'h0) begin
          eh = a;
          el = 32'hFFFF_FFFF;
        end else if (o == DIV) begin
          q  = sa / sb;
          r  = sa % sb;
          el = 32'(q);
          eh = 32'(r);
        end else begin
          el = a / b;
          eh = a % b;
        end
      end
      default: ;
    endcase
  endtask

  // Called at a falling edge: present the instruction for one cycle.
  task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    start = 1'b1;
    op    = o;
    in1   = a;
    in2   = b;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Called at the falling edge after the start edge; returns at the done cycle.
  task automatic finish_muldiv(input string tag, input logic [2:0] o,
                               input logic [31:0] a, input logic [31:0] b);
    int          n;
    logic [31:0] eh;
    logic [31:0] el;
    model(o, a, b, eh, el);
    n = 0;
    while (busy && n < 40) begin
      n++;
      @(negedge clk);
    end
    check({tag, " busy_cycles"}, 64'(n), 64'd33);
    check({tag, " done"}, 64'(done), 64'd1);
    check({tag, " hi"}, 64'(hi), 64'(eh));
    check({tag, " lo"}, 64'(lo), 64'(el));
    m_hi = eh;
    m_lo = el;
  endtask

  task automatic do_muldiv(input string tag, input logic [2:0] o,
                           input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    issue(o, a, b);
    finish_muldiv(tag, o, a, b);
    @(negedge clk);
    check({tag, " done_pulse"}, 64'(done), 64'd0);
  endtask

  task automatic do_move(input string tag, input logic [2:0] o, input logic [31:0] a);
    @(negedge clk);
    issue(o, a, 32'h0);
    if (o == MTHI) m_hi = a;
    if (o == MTLO) m_lo = a;
    check({tag, " hi"}, 64'(hi), 64'(m_hi));
    check({tag, " lo"}, 64'(lo), 64'(m_lo));
    check({tag, " busy"}, 64'(busy), 64'd0);
    check({tag, " done"}, 64'(done), 64'd0);
  endtask

  function automatic logic [31:0] rand_operand();
    case ($urandom_range(0, 5))
      0:       return 32'h0;
      1:       return $urandom_range(0, 15);
      2:       return 32'h8000_0000;
      3:       return 32'hFFFF_FFFF - $urandom_range(0, 15);
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int          seen_done;
    logic [2:0]  ro;
    logic [31:0] ra;
    logic [31:0] rb;

    reset = 1'b1;
    start = 1'b0;
    op    = 3'b000;
    in1   = 32'h0;
    in2   = 32'h0;
    flush = 1'b0;
    m_hi  = 32'h0;
    m_lo  = 32'h0;
    repeat (3) @(negedge clk);
    check("reset hi", 64'(hi), 64'h0);
    check("reset lo", 64'(lo), 64'h0);
    check("reset busy", 64'(busy), 64'h0);
    check("reset done", 64'(done), 64'h0);
    reset = 1'b0;

    do_muldiv("multu_max", MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    check("multu_max hi_const", 64'(hi), 64'hFFFF_FFFE);
    check("multu_max lo_const", 64'(lo), 64'h0000_0001);
    do_muldiv("mult_neg", MULT, 32'hFFFF_FFFD, 32'h0000_0007);
    check("mult_neg lo_const", 64'(lo), 64'hFFFF_FFEB);
    do_muldiv("div_neg", DIV, 32'hFFFF_FFF9, 32'h2);
    check("div_neg lo_const", 64'(lo), 64'hFFFF_FFFD);
    check("div_neg hi_const", 64'(hi), 64'hFFFF_FFFF);
    do_muldiv("divu", DIVU, 32'hFFFF_FFF9, 32'h2);
    check("divu lo_const", 64'(lo), 64'h7FFF_FFFC);
    do_muldiv("div0", DIV, 32'h5, 32'h0);
    check("div0 lo_const", 64'(lo), 64'hFFFF_FFFF);
    do_muldiv("divu0", DIVU, 32'h8000_0001, 32'h0);
    do_muldiv("div_ovf", DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    check("div_ovf lo_const", 64'(lo), 64'h8000_0000);
    check("div_ovf hi_const", 64'(hi), 64'h0);

    // Flush mid-RUN leaves HI/LO untouched and never pulses done.
    do_move("mthi", MTHI, 32'h1234_5678);
    @(negedge clk);
    issue(MULT, 32'h3, 32'h4);
    repeat (9) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("flush busy", 64'(busy), 64'd0);
    check("flush hi", 64'(hi), 64'h1234_5678);
    check("flush lo", 64'(lo), 64'(m_lo));
    seen_done = 0;
    repeat (40) begin
      if (done) seen_done++;
      @(negedge clk);
    end
    check("flush no_done", 64'(seen_done), 64'd0);

    // Flush beats a same-cycle MTHI.
    start = 1'b1;
    op    = MTHI;
    in1   = 32'hDEAD_BEEF;
    flush = 1'b1;
    @(negedge clk);
    start = 1'b0;
    flush = 1'b0;
    check("flush_mthi hi", 64'(hi), 64'(m_hi));

    // Reserved op does nothing.
    do_move("reserved", 3'b110, 32'hCAFE_F00D);

    // Asynchronous reset mid-RUN.
    do_move("mtlo", MTLO, 32'hA5A5_0F0F);
    @(negedge clk);
    issue(MULT, 32'h3, 32'h4);
    repeat (9) @(negedge clk);
    reset = 1'b1;
    #1;
    check("rst_mid hi", 64'(hi), 64'h0);
    check("rst_mid lo", 64'(lo), 64'h0);
    check("rst_mid busy", 64'(busy), 64'h0);
    m_hi = 32'h0;
    m_lo = 32'h0;
    @(negedge clk);
    reset = 1'b0;

    // Back-to-back: second op issued on the done cycle of the first.
    @(negedge clk);
    issue(MULTU, 32'h2, 32'h3);
    finish_muldiv("b2b_first", MULTU, 32'h2, 32'h3);
    issue(DIVU, 32'h9, 32'h2);
    finish_muldiv("b2b_second", DIVU, 32'h9, 32'h2);
    check("b2b_second lo_const", 64'(lo), 64'h4);
    check("b2b_second hi_const", 64'(hi), 64'h1);
    @(negedge clk);
    check("b2b done_pulse", 64'(done), 64'd0);

    // Randomized mix of all operation classes.
    for (int i = 0; i < 40; i++) begin
      ro = 3'($urandom_range(0, 7));
      ra = rand_operand();
      rb = rand_operand();
      if (ro[2] == 1'b0) do_muldiv($sformatf("rand%0d_op%0d", i, ro), ro, ra, rb);
      else               do_move($sformatf("rand%0d_op%0d", i, ro), ro, ra);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
